hm01b0_pixel_source: RTL
========================

# hm01b0_pixel_source

Synthesizable HM01B0 camera emulator. It drives the same parallel pixel bus (pclk, vsync, hsync, 8-bit data) that the compressor's ingester receives, and fills each frame with a selectable test pattern. It serves as the bench stimulus for the ingester and the full compressor, and as an on-board stand-in when no sensor is fitted.

## Interface
Parameters:
- `H_ACTIVE`, 320: pixels per line.
- `V_ACTIVE`, 240: lines per frame.
- `H_BLANK`, 16: pclk cycles with hsync low between lines.
- `V_FRONT`, 8: pclk cycles with vsync high before the first line.
- `V_BACK`, 8: pclk cycles with vsync high after the last line.
- `FRAME_GAP`, 32: pclk cycles with vsync low between frames.
- `CLK_DIV`, 4: clock cycles per pclk period. Even, ≥2.

Ports:
- `clock`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high.
- `enable`  in  1: run frames continuously while high.
- `pattern`  in  2: 0 gradient, 1 8×8 checker, 2 constant 0x80, 3 LFSR.
- `pclk`  out  1: pixel clock.
- `vsync`  out  1: frame valid, active high.
- `hsync`  out  1: line valid, active high.
- `data`  out  8: pixel data.
- `busy`  out  1: high from frame start until the end of FRAME_GAP.
- `frame_done`  out  1: one-clock pulse when FRAME_GAP ends.

## Operation
- **Reset values:** every output is 0, state is IDLE, and the internal frame counter is 0.
- **Clock divider:**
  - `div_cnt` counts 0..CLK_DIV-1 and runs whenever reset is low.
  - `pclk` = (div_cnt ≥ CLK_DIV/2).
  - A "tick" is the clock edge where div_cnt wraps to 0, i.e. the edge where pclk falls.
- **Update rule:** vsync, hsync, data and all FSM transitions update only on ticks. The one exception is `frame_done`, described below.
- **FSM states** (each pclk-cycle count is measured in ticks):
  - IDLE: vsync=0, hsync=0. On a tick with enable=1, latch `pattern`, reset the LFSR to 0xA5, go to VFRONT, set busy=1.
  - VFRONT: vsync=1 for V_FRONT ticks, then LINE.
  - LINE: hsync=1 for H_ACTIVE ticks, with x running 0..H_ACTIVE-1.
    - After the last pixel, go to HBLANK if y < V_ACTIVE-1, otherwise VBACK.
  - HBLANK: hsync=0, vsync=1 for H_BLANK ticks, then y++ and LINE.
  - VBACK: vsync=1 for V_BACK ticks, then GAP.
  - GAP: vsync=0 for FRAME_GAP ticks. At the end:
    - pulse frame_done for one clock and increment the frame counter (8-bit, wrapping);
    - go to VFRONT (relatch pattern, reset LFSR) if enable=1, else to IDLE with busy=0.
- **Pixel value** (only during LINE; data=0x00 in all other states):
  - gradient: (x + y + frame_cnt) mod 256.
  - checker: ((x>>3) ^ (y>>3)) & 1 ? 0xFF : 0x00.
  - constant: 0x80.
  - LFSR: current state, which advances once per LINE tick using next = {s[6:0], s7^s5^s4^s3}.
- **Widths:** x uses clog2(H_ACTIVE) bits and y uses clog2(V_ACTIVE) bits. The blanking counter is sized to the largest of H_BLANK, V_FRONT, V_BACK and FRAME_GAP. All sums are truncated to 8 bits.
- **Boundary conditions:**
  - Deasserting enable mid-frame has no effect until the current frame, including GAP, completes.
  - Changing `pattern` mid-frame is ignored until the next frame start.
  - Asserting reset mid-frame forces all outputs to 0 immediately. After release, the next frame starts at y=0 with frame_cnt=0.

## Timing
- data, hsync and vsync change only on the clock edge where pclk falls. They are stable for CLK_DIV/2 clocks before, and CLK_DIV/2 clocks after, each rising edge of pclk, where the receiver samples.
- Latency from enable rising (sampled on a tick) to the first rising edge of vsync is one tick.
- The first LINE pixel appears V_FRONT ticks after vsync rises.
- Frame length in ticks is V_FRONT + V_ACTIVE·H_ACTIVE + (V_ACTIVE-1)·H_BLANK + V_BACK + FRAME_GAP.
- `frame_done` is asserted on the clock edge after the final GAP tick and lasts exactly one clock.

## Structure
- Shared package `hm01b0_pkg` holds:
  - the pattern enum (GRADIENT, CHECKER, CONSTANT, LFSR);
  - the FSM state enum (IDLE, VFRONT, LINE, HBLANK, VBACK, GAP);
  - the LFSR seed constant 0xA5.
- One sub-module, `hm01b0_pattern_gen`, is natural. It takes x, y, frame_cnt, the latched pattern, a per-pixel advance strobe and a per-frame restart strobe, and returns the 8-bit pixel. It owns the LFSR.
- The top level contains the divider, the FSM and the counters.

## Test plan
Unless noted, all scenarios use H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, V_FRONT=3, V_BACK=2, FRAME_GAP=4, CLK_DIV=4.
1. **Gradient capture.** Gradient pattern, enable=1 → 4 hsync bursts of 8 pixels. Line 0 = 00..07, line 3 = 03..0A. The second frame's line 0 = 01..08.
2. **Bus timing.** Check that pclk has period 4 clocks and 50% duty. Check that data, hsync and vsync change only on falling-pclk edges. Check 3 pclk cycles from vsync rising to hsync rising.
3. **Checker pattern.** Checker with H_ACTIVE=16, V_ACTIVE=16 → line 0: pixels 0–7 = 00, 8–15 = FF. Line 8: pixels 0–7 = FF.
4. **LFSR pattern.** LFSR pattern → pixels 0 and 1 of every frame are A5 and 4A.
5. **Enable dropped mid-frame.** Drop enable during line 1 → all 4 lines still complete, one frame_done pulse is seen, then busy=0 and vsync stays 0.
6. **Reset mid-frame.** Assert reset mid-LINE → all outputs read 0 within the same clock. After release and enable, the frame restarts with line 0 = 00..07.

Source files
------------

// File: rtl/hm01b0_pkg.sv
// Shared types and constants for the HM01B0 camera emulator.
package hm01b0_pkg;

    typedef enum logic [1:0] {
        GRADIENT = 2'd0,
        CHECKER  = 2'd1,
        CONSTANT = 2'd2,
        LFSR     = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VFRONT = 3'd1,
        LINE   = 3'd2,
        HBLANK = 3'd3,
        VBACK  = 3'd4,
        GAP    = 3'd5
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/hm01b0_pattern_gen.sv
// Test-pattern pixel generator; owns the per-frame LFSR.
module hm01b0_pattern_gen
    import hm01b0_pkg::*;
#(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [7:0]    frame_cnt,
    input  pattern_e      pat,
    input  logic          advance,
    input  logic          restart,
    output logic [7:0]    pixel
);

    logic [7:0] lfsr;
    logic [7:0] x8;
    logic [7:0] y8;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (restart) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Coordinates folded to 8 bits: gradient wraps mod 256, checker only needs bit 3.
    assign x8 = 8'(x);
    assign y8 = 8'(y);

    always_comb begin
        pixel = 8'h00;
        case (pat)
            GRADIENT: pixel = x8 + y8 + frame_cnt;
            CHECKER:  pixel = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
            CONSTANT: pixel = 8'h80;
            LFSR:     pixel = lfsr;
            default:  pixel = 8'h00;
        endcase
    end

endmodule

// File: rtl/hm01b0_pixel_source.sv
// HM01B0 parallel-bus emulator: pclk divider, frame/line timing FSM, test patterns.
// state  | meaning
// IDLE   | bus quiet, waiting for enable on a tick
// VFRONT | vsync high before first line
// LINE   | hsync high, one pixel per tick
// HBLANK | hsync low between lines
// VBACK  | vsync high after last line
// GAP    | vsync low between frames, frame_done at its end
module hm01b0_pixel_source
    import hm01b0_pkg::*;
#(
    parameter int H_ACTIVE  = 320,
    parameter int V_ACTIVE  = 240,
    parameter int H_BLANK   = 16,
    parameter int V_FRONT   = 8,
    parameter int V_BACK    = 8,
    parameter int FRAME_GAP = 32,
    parameter int CLK_DIV   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern,
    output logic       pclk,
    output logic       vsync,
    output logic       hsync,
    output logic [7:0] data,
    output logic       busy,
    output logic       frame_done
);

    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BMAX1 = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
    localparam int BMAX2 = (V_BACK > FRAME_GAP) ? V_BACK : FRAME_GAP;
    localparam int BMAX  = (BMAX1 > BMAX2) ? BMAX1 : BMAX2;
    localparam int BW    = $clog2(BMAX + 1);
    localparam int DW    = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt;
    logic          tick;
    state_e        state;
    pattern_e      pat_q;
    logic [BW-1:0] cnt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    frame_cnt;
    logic [7:0]    pixel;
    logic          gap_end;
    logic          start_frame;

    assign tick = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Ticks are the falling pclk edges, so bus updates sit half a period from sampling.
    assign pclk = (div_cnt >= DW'(CLK_DIV / 2));

    assign gap_end     = (state == GAP) && (cnt == '0);
    assign start_frame = tick && enable && ((state == IDLE) || gap_end);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pat_q      <= GRADIENT;
            cnt        <= '0;
            x          <= '0;
            y          <= '0;
            frame_cnt  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start_frame) begin
                state <= VFRONT;
                cnt   <= BW'(V_FRONT - 1);
                pat_q <= pattern_e'(pattern);
                busy  <= 1'b1;
                x     <= '0;
                y     <= '0;
            end else if (tick) begin
                case (state)
                    VFRONT: begin
                        if (cnt == '0) state <= LINE;
                        else           cnt   <= cnt - BW'(1);
                    end
                    LINE: begin
                        if (x == XW'(H_ACTIVE - 1)) begin
                            x <= '0;
                            if (y == YW'(V_ACTIVE - 1)) begin
                                state <= VBACK;
                                cnt   <= BW'(V_BACK - 1);
                            end else begin
                                state <= HBLANK;
                                cnt   <= BW'(H_BLANK - 1);
                            end
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                    HBLANK: begin
                        if (cnt == '0) begin
                            state <= LINE;
                            y     <= y + YW'(1);
                        end else begin
                            cnt <= cnt - BW'(1);
                        end
                    end
                    VBACK: begin
                        if (cnt == '0) begin
                            state <= GAP;
                            cnt   <= BW'(FRAME_GAP - 1);
                        end else begin
                            cnt <= cnt - BW'(1);
                        end
                    end
                    GAP: begin
                        if (cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - BW'(1);
                        end
                    end
                    default: ;
                endcase
            end
            if (tick && gap_end) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
            end
        end
    end

    hm01b0_pattern_gen #(
        .XW(XW),
        .YW(YW)
    ) u_pattern_gen (
        .clock     (clock),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .frame_cnt (frame_cnt),
        .pat       (pat_q),
        .advance   (tick && (state == LINE)),
        .restart   (start_frame),
        .pixel     (pixel)
    );

    assign vsync = (state != IDLE) && (state != GAP);
    assign hsync = (state == LINE);
    assign data  = hsync ? pixel : 8'h00;

endmodule
